// File: rtl/sram_pkg.sv
// sram_pkg: shared types and constants for the 32-bit to 16-bit SRAM bridge.
package sram_pkg;
   localparam int SRAM_DW = 16;
   localparam int SRAM_AW = 18;
   localparam logic [31:0] SRAM_BASE_ADDR = 32'd1024;
   typedef enum logic [2:0] {
      IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, DONE
   } sram_ctrl_state_t;
endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits 32-bit MEM-stage loads/stores into two 16-bit synchronous SRAM accesses,
// low half first, stalling the pipeline through ready while the access is in flight.
module sram_ctrl
   import sram_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = SRAM_BASE_ADDR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_UB_N,
   output logic               SRAM_LB_N,
   output logic               SRAM_WE_N,
   output logic               SRAM_CE_N,
   output logic               SRAM_OE_N
);
   sram_ctrl_state_t state_q, state_d;
   logic [16:0] word_q, word_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] offset;
   logic        unused_offset;
   logic        wr_phase;
   logic        lo_phase;
   logic        hi_phase;

   assign offset        = address - BASE_ADDR;
   assign unused_offset = ^{offset[31:19], offset[1:0]};

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: if (wr_en | rd_en) begin
            state_d = wr_en ? WR_LO : RD_LO;
            word_d  = offset[18:2];
            wdata_d = write_data;
         end
         WR_LO:  state_d = WR_HI;
         WR_HI:  state_d = DONE;
         RD_LO:  state_d = RD_HI;
         // SRAM data lags its address by one edge, so each half lands a state later
         RD_HI: begin
            state_d        = RD_CAP;
            rdata_d[15:0]  = SRAM_DQ;
         end
         RD_CAP: begin
            state_d        = DONE;
            rdata_d[31:16] = SRAM_DQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         word_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign wr_phase  = (state_q == WR_LO) || (state_q == WR_HI);
   assign lo_phase  = (state_q == WR_LO) || (state_q == RD_LO);
   assign hi_phase  = (state_q == WR_HI) || (state_q == RD_HI) || (state_q == RD_CAP);

   assign SRAM_DQ   = wr_phase ? ((state_q == WR_HI) ? wdata_q[31:16] : wdata_q[15:0]) : 'z;
   assign SRAM_WE_N = ~wr_phase;
   assign SRAM_ADDR = lo_phase ? {word_q, 1'b0} : hi_phase ? {word_q, 1'b1} : '0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_OE_N = 1'b0;
   assign read_data = rdata_q;
   assign ready     = ~(wr_en | rd_en) | (state_q == DONE);
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: drives loads/stores against a behavioural synchronous SRAM and scoreboards the results.
module tb_sram_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   wire  [15:0] dq;
   logic [17:0] sram_addr;
   logic        ub_n, lb_n, we_n, ce_n, oe_n;

   logic [15:0] mem [0:15];
   logic [15:0] rd_reg = '0;
   logic        model_en = 1'b0;
   logic [31:0] exp_q [$];
   int          n_chk = 0;
   int          n_pass = 0;

   sram_ctrl dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(dq),
      .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n),
      .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
   );

   always #5 clk = ~clk;

   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup (dq[i]);
   end

   // SRAM: writes on the edge, registers read data on the edge and drives it the next cycle
   assign dq = (model_en && we_n) ? rd_reg : 'z;
   always @(posedge clk) begin
      if (!we_n) mem[sram_addr[3:0]] <= dq;
      rd_reg <= mem[sram_addr[3:0]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic do_req(input logic we, input logic re, input logic [31:0] a,
                         input logic [31:0] d, input int exp_cyc, input int exp_we, input string tag);
      int c;
      int we_cnt;
      we_cnt = 0;
      @(negedge clk);
      wr_en = we; rd_en = re; address = a; write_data = d;
      if (re && !we) exp_q.push_back({mem[{a[4:2], 1'b1}], mem[{a[4:2], 1'b0}]});
      #1 chk({tag, " ready_c0"}, {31'd0, ready}, 32'd0);
      for (c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (!we_n) we_cnt++;
         if (c == 1) begin
            address = 32'h0000_0BAD;
            write_data = 32'h5A5A_A5A5;
         end
         if (ready) break;
      end
      chk({tag, " ready_cycle"}, c, exp_cyc);
      chk({tag, " we_cycles"}, we_cnt, exp_we);
      if (re && !we) begin
         if (exp_q.size() == 0) chk({tag, " queue_empty"}, 32'd1, 32'd0);
         else chk({tag, " read_data"}, read_data, exp_q.pop_front());
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);
      repeat (2) @(negedge clk);
      chk("rst read_data", read_data, 32'd0);
      chk("rst we_n", {31'd0, we_n}, 32'd1);
      chk("rst addr", {14'd0, sram_addr}, 32'd0);
      chk("rst tied", {28'd0, ub_n, lb_n, ce_n, oe_n}, 32'd0);
      chk("rst ready", {31'd0, ready}, 32'd1);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("idle ready", {31'd0, ready}, 32'd1);
         chk("idle dq", {16'd0, dq}, 32'h0000_FFFF);
         chk("idle we_n", {31'd0, we_n}, 32'd1);
      end
      model_en = 1'b1;
      do_req(1, 0, 32'd1024, 32'hDEADBEEF, 3, 2, "st0");
      chk("st0 w0", {16'd0, mem[0]}, 32'h0000_BEEF);
      chk("st0 w1", {16'd0, mem[1]}, 32'h0000_DEAD);
      do_req(0, 1, 32'd1024, 32'd0, 4, 0, "ld0");
      do_req(1, 0, 32'd1028, 32'h12345678, 3, 2, "st1");
      chk("st1 w2", {16'd0, mem[2]}, 32'h0000_5678);
      chk("st1 w3", {16'd0, mem[3]}, 32'h0000_1234);
      chk("st1 w0", {16'd0, mem[0]}, 32'h0000_BEEF);
      chk("st1 w1", {16'd0, mem[1]}, 32'h0000_DEAD);
      do_req(1, 1, 32'd1032, 32'hCAFEF00D, 3, 2, "both");
      chk("both w4", {16'd0, mem[4]}, 32'h0000_F00D);
      chk("both w5", {16'd0, mem[5]}, 32'h0000_CAFE);
      chk("both read_data", read_data, 32'hDEADBEEF);
      do_req(0, 1, 32'd1028, 32'd0, 4, 0, "ld1");
      model_en = 1'b0;
      @(negedge clk);
      wr_en = 1'b1; address = 32'd1036; write_data = 32'hAAAA5555;
      @(negedge clk);
      @(negedge clk);
      chk("abort in_wr_hi", {31'd0, we_n}, 32'd0);
      rst = 1'b1; wr_en = 1'b0;
      #1;
      chk("abort we_n", {31'd0, we_n}, 32'd1);
      chk("abort dq", {16'd0, dq}, 32'h0000_FFFF);
      chk("abort read_data", read_data, 32'd0);
      chk("abort addr", {14'd0, sram_addr}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort w6", {16'd0, mem[6]}, 32'h0000_5555);
      chk("abort w7", {16'd0, mem[7]}, 32'h0000_1007);
      model_en = 1'b1;
      do_req(0, 1, 32'd1036, 32'd0, 4, 0, "ld2");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Memory-stage bridge between the ARM pipeline's 32-bit load/store port and the external 16-bit synchronous SRAM. It splits each 32-bit request into two 16-bit SRAM accesses: low half first, high half second. While the access is in flight it holds `ready` low so the hazard/freeze logic stalls the pipeline. It drives the SRAM pins as bus initiator and owns the `SRAM_DQ` tristate when writing.

## Interface
Parameters:
- BASE_ADDR, 32'd1024, first byte address of data memory; subtracted before mapping.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  store request from MEM stage.
- rd_en  in  1  load request from MEM stage.
- address  in  32  byte address; must be word-aligned (bits [1:0] ignored).
- write_data  in  32  store data.
- read_data  out  32  load result; registered.
- ready  out  1  high when no request is pending or the current request completes this cycle.
- SRAM_DQ  inout  16  data bus; driven only in write states, else high-Z.
- SRAM_ADDR  out  18  16-bit word address at the SRAM.
- SRAM_UB_N, SRAM_LB_N  out  1 each  byte enables; tied 0.
- SRAM_CE_N, SRAM_OE_N  out  1 each  tied 0.
- SRAM_WE_N  out  1  write strobe, active-low.

## Operation
- Address mapping: `w = (address - BASE_ADDR) >> 2`.
  - Low half goes to `SRAM_ADDR = {w[16:0],1'b0}`.
  - High half goes to `{w[16:0],1'b1}`.
  - Upper bits of `w` beyond 17 are discarded.
- `address` and `write_data` are registered at acceptance; later input changes do not affect the access in flight.
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_CAP, DONE.
- IDLE:
  - `wr_en` → WR_LO.
  - Else `rd_en` → RD_LO.
  - Else stay in IDLE.
  - Write wins when both are high.
- WR_LO: `SRAM_WE_N=0`, `SRAM_DQ=wdata[15:0]`, address = low half. Next state WR_HI.
- WR_HI: `SRAM_WE_N=0`, `SRAM_DQ=wdata[31:16]`, address = high half. Next state DONE.
- RD_LO: `SRAM_WE_N=1`, address = low half. Next state RD_HI.
- RD_HI: address = high half; capture `SRAM_DQ` into `read_data[15:0]` at the closing edge. Next state RD_CAP.
- RD_CAP: address = high half; capture `SRAM_DQ` into `read_data[31:16]` at the closing edge. Next state DONE.
- DONE: `SRAM_WE_N=1`, DQ high-Z. Next state IDLE unconditionally.
- ready (combinational): `ready = ~(wr_en|rd_en) | (state==DONE)`.
- `read_data` holds its last loaded value until the next read capture; writes never alter it.

## Timing
- Reset values:
  - state IDLE, `read_data=0`.
  - `SRAM_WE_N=1`, `SRAM_DQ` high-Z, `SRAM_ADDR=0`.
  - CE_N/OE_N/UB_N/LB_N = 0.
  - `ready=1` when no request is present.
- SRAM read latency: the SRAM registers data one edge after it sees the address and drives it during the following cycle. This is why each half is captured one state after its address is presented.
- Store: accepted at edge 0; SRAM writes occur at edges 1 and 2; `ready=1` during cycle 3 (DONE). A store occupies 3 cycles beyond IDLE.
- Load: accepted at edge 0; low half captured at edge 2, high half at edge 3; `ready=1` and `read_data` valid during cycle 4.
- Back-to-back: a request still asserted in the cycle after DONE is a new request and is accepted from IDLE. Minimum gap is one IDLE cycle.
- Reset mid-operation: abort immediately to IDLE, `SRAM_WE_N=1`, DQ released.
  - A store aborted after WR_LO has its low half written and its high half unchanged.
  - An aborted load leaves `read_data=0`.
- DQ turnaround: DQ is released in the same cycle `SRAM_WE_N` rises. The controller never drives DQ in any read state.

## Structure
- Shared package `sram_pkg`: state enum type `sram_ctrl_state_t`, constant `SRAM_BASE_ADDR = 1024`, widths `SRAM_DW=16`, `SRAM_AW=18`.
- No sub-module: the FSM, address mapper and tristate fit one module of about 150–200 lines.

## Test plan
- Idle: with no request, `ready=1`, DQ high-Z, `SRAM_WE_N=1` every cycle.
- Store 0xDEADBEEF to 1024:
  - SRAM word 0 = 0xBEEF, word 1 = 0xDEAD.
  - `SRAM_WE_N` low for exactly 2 cycles.
  - `ready` rises in cycle 3.
- Load from 1024 after that store: `read_data=0xDEADBEEF` and `ready=1` in cycle 4; `ready=0` in cycles 0–3.
- Store 0x12345678 to 1028: SRAM words 2/3 = 0x5678/0x1234; words 0/1 unchanged.
- `wr_en` and `rd_en` both high with address 1032, data 0xCAFEF00D: a write occurs (words 4/5 = 0xF00D/0xCAFE) and no read states are visited.
- Assert `rst` in WR_HI of a store 0xAAAA5555 to 1036:
  - word 6 = 0x5555, word 7 unchanged.
  - Immediately `SRAM_WE_N=1`, state IDLE, `read_data=0`.
